vram_wr_arb: RTL

VRAM write scheduler for the character generator: it sits between the CPU register bus and the single VRAM write port of the OSD character generator. It turns CPU register-bit write strobes into queued single writes and runs an optional hardware fill engine for clear-screen and line-clear operations. It arbitrates both sources onto one write per clock and can restrict writes to blanking, so the display never tears.

---
 rtl/vram_wr_pkg.sv | 24 ++
 rtl/vram_wr_arb_if.sv | 55 +++++
 rtl/vram_wr_fifo.sv | 73 +++++++
 rtl/vram_wr_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vram_wr_pkg.sv
// ---------------------------------------------------------------------------
// vram_wr_pkg
// Shared definitions for the OSD character-generator VRAM write scheduler.
//   C_VRAM_AW_DEF / C_VRAM_DW_DEF : default VRAM address / data widths
//   fill_state_e                  : fill engine state encoding
//   vram_wr_entry_t               : {addr,data} queue entry at default widths
// No ports (package).
// ---------------------------------------------------------------------------
package vram_wr_pkg;

  localparam int C_VRAM_AW_DEF = 10;
  localparam int C_VRAM_DW_DEF = 8;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic [C_VRAM_AW_DEF-1:0] addr;
    logic [C_VRAM_DW_DEF-1:0] data;
  } vram_wr_entry_t;

endpackage

// File: rtl/vram_wr_arb_if.sv
// ---------------------------------------------------------------------------
// vram_wr_arb_if
// Bus bundle between the CPU register block / video timing and vram_wr_arb.
//   CPU_WE_i, CPU_WAs_i, CPU_WDs_i       : CPU write strobe (level), addr, data
//   FILL_START_i, FILL_BASEs_i,
//   FILL_LENs_i, FILL_DATs_i             : fill engine request
//   BLANK_i, BLANK_ONLY_i                : write window control
//   VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o    : registered VRAM write port
//   CPU_FULL_o, DROP_o, FILL_BUSY_o,
//   FIFO_LVLs_o                          : status
// modport master : request side (drives the *_i signals)
// modport slave  : the scheduler (drives the *_o signals)
// ---------------------------------------------------------------------------
interface vram_wr_arb_if
  import vram_wr_pkg::*;
#(
  parameter int C_VRAM_AW = C_VRAM_AW_DEF,
  parameter int C_VRAM_DW = C_VRAM_DW_DEF,
  parameter int C_LVL_W   = 3
);

  logic                 CPU_WE_i;
  logic [C_VRAM_AW-1:0] CPU_WAs_i;
  logic [C_VRAM_DW-1:0] CPU_WDs_i;
  logic                 FILL_START_i;
  logic [C_VRAM_AW-1:0] FILL_BASEs_i;
  logic [C_VRAM_AW:0]   FILL_LENs_i;
  logic [C_VRAM_DW-1:0] FILL_DATs_i;
  logic                 BLANK_i;
  logic                 BLANK_ONLY_i;
  logic                 VRAM_WE_o;
  logic [C_VRAM_AW-1:0] VRAM_WAs_o;
  logic [C_VRAM_DW-1:0] VRAM_WDs_o;
  logic                 CPU_FULL_o;
  logic                 DROP_o;
  logic                 FILL_BUSY_o;
  logic [C_LVL_W-1:0]   FIFO_LVLs_o;

  modport master (
    output CPU_WE_i, CPU_WAs_i, CPU_WDs_i,
    output FILL_START_i, FILL_BASEs_i, FILL_LENs_i, FILL_DATs_i,
    output BLANK_i, BLANK_ONLY_i,
    input  VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o,
    input  CPU_FULL_o, DROP_o, FILL_BUSY_o, FIFO_LVLs_o
  );

  modport slave (
    input  CPU_WE_i, CPU_WAs_i, CPU_WDs_i,
    input  FILL_START_i, FILL_BASEs_i, FILL_LENs_i, FILL_DATs_i,
    input  BLANK_i, BLANK_ONLY_i,
    output VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o,
    output CPU_FULL_o, DROP_o, FILL_BUSY_o, FIFO_LVLs_o
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// ---------------------------------------------------------------------------
// vram_wr_fifo
// Synchronous in-order FIFO for queued CPU writes. A push while full is
// accepted when a pop happens in the same cycle.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write din_i (ignored when full and not popping)
//   pop_i        : advance head (ignored when empty)
//   din_i        : entry to push
//   dout_o       : head entry (valid when !empty_o)
//   full_o       : occupancy == C_DEPTH
//   empty_o      : occupancy == 0
//   lvl_o        : registered occupancy
// ---------------------------------------------------------------------------
module vram_wr_fifo
  import vram_wr_pkg::*;
#(
  parameter int  C_DEPTH = 4,
  parameter type entry_t = vram_wr_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  entry_t                   din_i,
  output entry_t                   dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(C_DEPTH):0] lvl_o
);

  localparam int PW = $clog2(C_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;
  localparam logic [LW-1:0] LVL_MAX = C_DEPTH;

  entry_t        mem_q [C_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] lvl_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (lvl_q == LVL_MAX);
  assign empty_o = (lvl_q == '0);
  assign lvl_o   = lvl_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // When full, wr_ptr == rd_ptr; the head is read before the slot is rewritten.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + LVL_ONE;
        2'b01:   lvl_q <= lvl_q - LVL_ONE;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/vram_wr_arb.sv
// ---------------------------------------------------------------------------
// vram_wr_arb
// VRAM write scheduler for the OSD character generator. Converts CPU write
// strobe edges into queued writes, runs the hardware fill engine and grants
// at most one VRAM write per clock, CPU first, optionally only in blanking.
// Compile-time option: VRAM_FILL_EN -- when undefined the fill engine is
// absent, FILL_* inputs are ignored and FILL_BUSY_o is 0.
//   CK_i    : system clock
//   SYS_R_i : asynchronous active-high reset
//   bus     : vram_wr_arb_if.slave (CPU, fill, blanking inputs; VRAM write
//             port and status outputs)
// ---------------------------------------------------------------------------
module vram_wr_arb
  import vram_wr_pkg::*;
#(
  parameter int C_VRAM_AW    = C_VRAM_AW_DEF,
  parameter int C_VRAM_DW    = C_VRAM_DW_DEF,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic         CK_i,
  input  logic         SYS_R_i,
  vram_wr_arb_if.slave bus
);

  localparam int LW = $clog2(C_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [C_VRAM_AW-1:0] addr;
    logic [C_VRAM_DW-1:0] data;
  } entry_t;

  logic                 we_d_q;
  logic                 push;
  logic                 ok;
  logic                 pop;
  logic                 fill_gnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_lvl;
  entry_t               cpu_entry;
  entry_t               cpu_head;
  logic [C_VRAM_AW-1:0] fill_wa;
  logic [C_VRAM_DW-1:0] fill_wd;
  logic                 vram_we_d, vram_we_q;
  logic [C_VRAM_AW-1:0] vram_wa_d, vram_wa_q;
  logic [C_VRAM_DW-1:0] vram_wd_d, vram_wd_q;
  logic                 drop_d, drop_q;

  assign push      = bus.CPU_WE_i & ~we_d_q;
  assign ok        = ~bus.BLANK_ONLY_i | bus.BLANK_i;
  assign pop       = ok & ~fifo_empty;
  assign cpu_entry = '{addr: bus.CPU_WAs_i, data: bus.CPU_WDs_i};
  assign drop_d    = push & fifo_full & ~pop;

  vram_wr_fifo #(
    .C_DEPTH (C_FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (CK_i),
    .rst_i   (SYS_R_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (cpu_entry),
    .dout_o  (cpu_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .lvl_o   (fifo_lvl)
  );

`ifdef VRAM_FILL_EN
  localparam logic [C_VRAM_AW-1:0] ADDR_ONE = 1;
  localparam logic [C_VRAM_AW:0]   REM_ONE  = 1;

  fill_state_e          state_q, state_d;
  logic [C_VRAM_AW-1:0] fill_addr_q;
  logic [C_VRAM_AW:0]   fill_rem_q;
  logic [C_VRAM_DW-1:0] fill_dat_q;
  logic                 fill_run;
  logic                 fill_load;

  assign fill_load = (state_q == F_IDLE) & bus.FILL_START_i & (bus.FILL_LENs_i != '0);
  assign fill_gnt  = ok & fifo_empty & fill_run;
  assign fill_wa   = fill_addr_q;
  assign fill_wd   = fill_dat_q;

  always_ff @(posedge CK_i or posedge SYS_R_i) begin
    if (SYS_R_i) state_q <= F_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (fill_load) state_d = F_RUN;
      F_RUN:   if (fill_gnt && fill_rem_q == REM_ONE) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    fill_run        = (state_q == F_RUN);
    bus.FILL_BUSY_o = fill_run;
  end

  // Range registers are only meaningful in F_RUN, which reset leaves.
  always_ff @(posedge CK_i) begin
    if (fill_load) begin
      fill_addr_q <= bus.FILL_BASEs_i;
      fill_rem_q  <= bus.FILL_LENs_i;
      fill_dat_q  <= bus.FILL_DATs_i;
    end else if (fill_gnt) begin
      fill_addr_q <= fill_addr_q + ADDR_ONE;
      fill_rem_q  <= fill_rem_q - REM_ONE;
    end
  end
`else
  logic unused_fill;

  assign unused_fill     = &{1'b0, bus.FILL_START_i, bus.FILL_BASEs_i,
                             bus.FILL_LENs_i, bus.FILL_DATs_i};
  assign fill_gnt        = 1'b0;
  assign fill_wa         = '0;
  assign fill_wd         = '0;
  assign bus.FILL_BUSY_o = 1'b0;
`endif

  // Grant: queued CPU write first, then fill; address/data hold when idle.
  always_comb begin
    vram_we_d = 1'b0;
    vram_wa_d = vram_wa_q;
    vram_wd_d = vram_wd_q;
    if (pop) begin
      vram_we_d = 1'b1;
      vram_wa_d = cpu_head.addr;
      vram_wd_d = cpu_head.data;
    end else if (fill_gnt) begin
      vram_we_d = 1'b1;
      vram_wa_d = fill_wa;
      vram_wd_d = fill_wd;
    end
  end

  always_ff @(posedge CK_i or posedge SYS_R_i) begin
    if (SYS_R_i) begin
      we_d_q    <= 1'b0;
      vram_we_q <= 1'b0;
      vram_wa_q <= '0;
      vram_wd_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      we_d_q    <= bus.CPU_WE_i;
      vram_we_q <= vram_we_d;
      vram_wa_q <= vram_wa_d;
      vram_wd_q <= vram_wd_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.VRAM_WE_o   = vram_we_q;
  assign bus.VRAM_WAs_o  = vram_wa_q;
  assign bus.VRAM_WDs_o  = vram_wd_q;
  assign bus.DROP_o      = drop_q;
  assign bus.CPU_FULL_o  = fifo_full;
  assign bus.FIFO_LVLs_o = fifo_lvl;

endmodule
